// File: rtl/kernel_pkg.sv
// Shared types and the preset kernel ROM for the convolution kernel bank.
package kernel_pkg;

   // Largest supported kernel edge; preset ROM entries are built on this grid.
   localparam int KMAX = 5;
   // Width of the preset ROM values; every preset fits in a signed byte.
   localparam int PW   = 8;

   typedef enum logic [2:0] {
      K_IDENTITY,
      K_GAUSS,
      K_SHARPEN,
      K_RIDGE,
      K_SOBEL_X,
      K_SOBEL_Y
   } preset_e;

   typedef enum logic [1:0] {
      L_IDLE,
      L_LOAD,
      L_COMMIT
   } load_state_e;

   typedef struct packed {
      logic [KMAX*KMAX-1:0][PW-1:0] coeffs;
      logic [PW-1:0]                shift;
      logic [PW-1:0]                offset;
   } kernel_t;

   // Words in one user-kernel write: every coefficient, then shift, then offset.
   function automatic int word_count(input int ksize);
      return ksize * ksize + 2;
   endfunction

   // Preset ROM; the 3x3 core is centred in a ksize x ksize grid with a zero border.
   function automatic kernel_t preset_kernel(input int idx, input int ksize);
      kernel_t k;
      int      g[9];
      int      off;
      k   = '0;
      off = (ksize - 3) / 2;
      g   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      case (idx)
         int'(K_GAUSS): begin
            g       = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
            k.shift = 8'd4;
         end
         int'(K_SHARPEN): begin
            g        = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
            k.offset = 8'd16;
         end
         int'(K_RIDGE): begin
            g        = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
            k.offset = 8'd16;
         end
         int'(K_SOBEL_X): g = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
         int'(K_SOBEL_Y): g = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
         default: ;
      endcase
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            k.coeffs[(r + off) * ksize + c + off] = PW'(g[r * 3 + c]);
      return k;
   endfunction

   function automatic kernel_t identity_kernel(input int ksize);
      return preset_kernel(int'(K_IDENTITY), ksize);
   endfunction

endpackage

// File: rtl/kernel_loader.sv
// Word-stream loader: stages one full user kernel, then hands it over in a
// single commit cycle so a half-written kernel is never visible.
module kernel_loader
   import kernel_pkg::*;
#(
   parameter int KSIZE = 3,
   parameter int CW    = 8,
   parameter int SLOTW = 1
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            wr_valid_in,
   output logic                            wr_ready_out,
   input  logic [SLOTW-1:0]                wr_slot_in,
   input  logic [CW-1:0]                   wr_data_in,
   output logic                            commit_out,
   output logic [SLOTW-1:0]                commit_slot_out,
   output logic [KSIZE*KSIZE+1:0][CW-1:0]  staging_out
);
   localparam int NW   = word_count(KSIZE);
   localparam int CNTW = $clog2(NW);

   load_state_e           st_q, st_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [SLOTW-1:0]      slot_q, slot_d;
   logic [NW-1:0][CW-1:0] stg_q, stg_d;
   logic                  rdy_q, rdy_d;
   logic                  acc;

   // Next state: count accepted words, stage them, drop ready for the commit cycle.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      slot_d = slot_q;
      stg_d  = stg_q;
      acc    = wr_valid_in && rdy_q;
      case (st_q)
         L_IDLE: if (acc) begin
            stg_d[0] = wr_data_in;
            slot_d   = wr_slot_in;
            cnt_d    = CNTW'(1);
            st_d     = L_LOAD;
         end
         L_LOAD: if (acc) begin
            stg_d[cnt_q] = wr_data_in;
            cnt_d        = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(NW - 1)) st_d = L_COMMIT;
         end
         default: st_d = L_IDLE;
      endcase
      // Ready is registered so it stays low through reset and the commit cycle.
      rdy_d = (st_d != L_COMMIT);
   end

   // Loader state; reset discards any partial staging.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         st_q   <= L_IDLE;
         cnt_q  <= '0;
         slot_q <= '0;
         stg_q  <= '0;
         rdy_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         slot_q <= slot_d;
         stg_q  <= stg_d;
         rdy_q  <= rdy_d;
      end
   end

   assign wr_ready_out    = rdy_q;
   assign commit_out      = (st_q == L_COMMIT);
   assign commit_slot_out = slot_q;
   assign staging_out     = stg_q;

endmodule

// File: rtl/kernel_bank.sv
// Runtime-selectable kernel source: presets plus user slots, with the active
// kernel swapped only on frame_start so the datapath never sees a torn kernel.
module kernel_bank
   import kernel_pkg::*;
#(
   parameter int KSIZE       = 3,
   parameter int CW          = 8,
   parameter int NUM_PRESETS = 6,
   parameter int NUM_USER    = 2,
   parameter int SELW        = 3,
   parameter int SLOTW       = (NUM_USER > 1) ? $clog2(NUM_USER) : 1
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [SELW-1:0]           sel_in,
   input  logic                      sel_valid_in,
   input  logic                      frame_start_in,
   input  logic                      wr_valid_in,
   output logic                      wr_ready_out,
   input  logic [SLOTW-1:0]          wr_slot_in,
   input  logic [CW-1:0]             wr_data_in,
   output logic [KSIZE*KSIZE*CW-1:0] coeffs_out,
   output logic [CW-1:0]             shift_out,
   output logic [CW-1:0]             offset_out,
   output logic [SELW-1:0]           kernel_id_out,
   output logic                      pending_out,
   output logic                      sel_err_out
);
   localparam int KK   = KSIZE * KSIZE;
   localparam int NW   = word_count(KSIZE);
   localparam int NSEL = NUM_PRESETS + NUM_USER;

   typedef logic [NW-1:0][CW-1:0] kwords_t;

   // Sign-extend a ROM entry to CW-wide words in write-stream order.
   function automatic kwords_t to_words(input kernel_t k);
      kwords_t w;
      w = '0;
      for (int i = 0; i < KK; i++) w[i] = CW'($signed(k.coeffs[i]));
      w[NW-2] = CW'($signed(k.shift));
      w[NW-1] = CW'($signed(k.offset));
      return w;
   endfunction

   kwords_t                    id_w, src_w, staging;
   kwords_t                    act_q, act_d;
   logic [NUM_USER-1:0][NW-1:0][CW-1:0] user_q, user_d;
   logic [SELW-1:0]            kid_q, kid_d, psel_q, psel_d, src_sel;
   logic                       pend_q, pend_d, err_q, err_d, sel_ok;
   logic                       commit;
   logic [SLOTW-1:0]           commit_slot;

   kernel_loader #(.KSIZE(KSIZE), .CW(CW), .SLOTW(SLOTW)) u_loader (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .wr_valid_in     (wr_valid_in),
      .wr_ready_out    (wr_ready_out),
      .wr_slot_in      (wr_slot_in),
      .wr_data_in      (wr_data_in),
      .commit_out      (commit),
      .commit_slot_out (commit_slot),
      .staging_out     (staging)
   );

   // Source for a frame_start: a same-cycle select bypasses the pending one.
   always_comb begin
      id_w    = to_words(identity_kernel(KSIZE));
      sel_ok  = sel_valid_in && (int'(sel_in) < NSEL);
      src_sel = pend_q ? psel_q : kid_q;
      if (sel_ok) src_sel = sel_in;
      src_w = to_words(preset_kernel(int'(src_sel), KSIZE));
      for (int u = 0; u < NUM_USER; u++)
         if (int'(src_sel) == NUM_PRESETS + u) src_w = user_q[u];
   end

   // Selection, frame-boundary apply and slot commit; frame_start sees pre-commit slots.
   always_comb begin
      pend_d = pend_q;
      psel_d = psel_q;
      kid_d  = kid_q;
      act_d  = act_q;
      user_d = user_q;
      err_d  = sel_valid_in && !sel_ok;
      if (sel_ok) begin
         pend_d = 1'b1;
         psel_d = sel_in;
      end
      if (frame_start_in) begin
         act_d  = src_w;
         kid_d  = src_sel;
         pend_d = 1'b0;
      end
      for (int u = 0; u < NUM_USER; u++)
         if (commit && int'(commit_slot) == u) user_d[u] = staging;
   end

   // Bank, selection and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         act_q  <= id_w;
         user_q <= {NUM_USER{id_w}};
         kid_q  <= '0;
         psel_q <= '0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         act_q  <= act_d;
         user_q <= user_d;
         kid_q  <= kid_d;
         psel_q <= psel_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign coeffs_out    = act_q[KK-1:0];
   assign shift_out     = act_q[NW-2];
   assign offset_out    = act_q[NW-1];
   assign kernel_id_out = kid_q;
   assign pending_out   = pend_q;
   assign sel_err_out   = err_q;

endmodule

// File: tb/tb_kernel_bank.sv
// Randomized scoreboard bench for kernel_bank with a word-level reference model.
module tb_kernel_bank;
   localparam int KSIZE = 3, CW = 8, NP = 6, NU = 2, SELW = 3;
   localparam int KK = KSIZE * KSIZE, NW = KK + 2;

   logic clk_in = 1'b0, rst_n_in = 1'b1;
   logic [SELW-1:0] sel_in = '0;
   logic sel_valid_in = 1'b0, frame_start_in = 1'b0, wr_valid_in = 1'b0;
   logic wr_ready_out;
   logic [0:0] wr_slot_in = '0;
   logic [CW-1:0] wr_data_in = '0;
   logic [KK*CW-1:0] coeffs_out;
   logic [CW-1:0] shift_out, offset_out;
   logic [SELW-1:0] kernel_id_out;
   logic pending_out, sel_err_out;

   // second instance with a single user slot, for out-of-range selects
   logic [SELW-1:0] sel1 = '0;
   logic sv1 = 1'b0, rdy1, pend1, err1;
   logic [KK*CW-1:0] coeffs1;
   logic [CW-1:0] shift1, offset1;
   logic [SELW-1:0] kid1;

   always #5 clk_in = ~clk_in;

   kernel_bank #(.KSIZE(KSIZE), .CW(CW), .NUM_PRESETS(NP), .NUM_USER(NU), .SELW(SELW)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .sel_in(sel_in), .sel_valid_in(sel_valid_in),
      .frame_start_in(frame_start_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
      .wr_slot_in(wr_slot_in), .wr_data_in(wr_data_in), .coeffs_out(coeffs_out),
      .shift_out(shift_out), .offset_out(offset_out), .kernel_id_out(kernel_id_out),
      .pending_out(pending_out), .sel_err_out(sel_err_out));

   kernel_bank #(.KSIZE(KSIZE), .CW(CW), .NUM_PRESETS(NP), .NUM_USER(1), .SELW(SELW)) dut1 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .sel_in(sel1), .sel_valid_in(sv1),
      .frame_start_in(1'b0), .wr_valid_in(1'b0), .wr_ready_out(rdy1),
      .wr_slot_in(1'b0), .wr_data_in(8'h00), .coeffs_out(coeffs1),
      .shift_out(shift1), .offset_out(offset1), .kernel_id_out(kid1),
      .pending_out(pend1), .sel_err_out(err1));

   // reference model: the bank as plain integer tables
   int ptab[NP][KK] = '{'{0,0,0,0,1,0,0,0,0}, '{1,2,1,2,4,2,1,2,1},
                        '{0,-1,0,-1,5,-1,0,-1,0}, '{-1,-1,-1,-1,8,-1,-1,-1,-1},
                        '{1,0,-1,2,0,-2,1,0,-1}, '{-1,-2,-1,0,0,0,1,2,1}};
   int psh[NP]  = '{0, 4, 0, 0, 0, 0};
   int poff[NP] = '{0, 0, 16, 16, 0, 0};
   int m_user[NU][NW];
   int m_act[NW];
   int stage[NW];
   int m_kid, m_psel, m_cnt, m_slot;
   bit m_pend, m_err, m_commit, m_ready;

   typedef struct packed {
      logic [NW-1:0][7:0] w;
      logic [2:0]         kid;
   } exp_t;
   exp_t exp_q[$];

   int n_tests = 0, n_fail = 0;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] w8(input int v);
      logic [7:0] b;
      b = 8'(v);
      return 128'(b);
   endfunction

   function automatic int bank_word(input int idx, input int i);
      if (idx >= NP) return m_user[idx-NP][i];
      if (i < KK) return ptab[idx][i];
      return (i == KK) ? psh[idx] : poff[idx];
   endfunction

   function automatic logic [127:0] exp_coeffs();
      logic [KK*CW-1:0] v;
      for (int i = 0; i < KK; i++) v[i*CW +: CW] = CW'(m_act[i]);
      return 128'(v);
   endfunction

   function automatic void m_reset();
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < NW; i++) m_user[u][i] = bank_word(0, i);
      for (int i = 0; i < NW; i++) m_act[i] = bank_word(0, i);
      m_kid = 0; m_psel = 0; m_cnt = 0; m_slot = 0;
      m_pend = 0; m_err = 0; m_commit = 0; m_ready = 0;
      exp_q.delete();
   endfunction

   // model update for one rising edge, from the inputs presented at that edge
   function automatic void m_edge();
      bit ok;
      int src;
      exp_t e;
      ok = sel_valid_in && (int'(sel_in) < NP + NU);
      if (frame_start_in) begin
         src = ok ? int'(sel_in) : (m_pend ? m_psel : m_kid);
         for (int i = 0; i < NW; i++) m_act[i] = bank_word(src, i);
         m_kid = src;
         m_pend = 0;
         for (int i = 0; i < NW; i++) e.w[i] = 8'(m_act[i]);
         e.kid = 3'(src);
         exp_q.push_back(e);
      end else if (ok) begin
         m_pend = 1;
         m_psel = int'(sel_in);
      end
      m_err = sel_valid_in && !ok;
      if (m_commit) begin
         for (int i = 0; i < NW; i++) m_user[m_slot][i] = stage[i];
         m_commit = 0;
      end else if (wr_valid_in && m_ready) begin
         if (m_cnt == 0) m_slot = int'(wr_slot_in);
         stage[m_cnt] = int'($signed(wr_data_in));
         m_cnt++;
         if (m_cnt == NW) begin
            m_commit = 1;
            m_cnt = 0;
         end
      end
      m_ready = !m_commit;
   endfunction

   task automatic check_state();
      chk("ready", 128'(wr_ready_out), 128'(m_ready));
      chk("pending", 128'(pending_out), 128'(m_pend));
      chk("kernel_id", 128'(kernel_id_out), 128'(m_kid));
      chk("sel_err", 128'(sel_err_out), 128'(m_err));
      chk("coeffs", 128'(coeffs_out), exp_coeffs());
      chk("shift", 128'(shift_out), w8(m_act[NW-2]));
      chk("offset", 128'(offset_out), w8(m_act[NW-1]));
   endtask

   task automatic step();
      @(posedge clk_in);
      if (rst_n_in) m_edge();
      #1;
      sel_valid_in = 0; frame_start_in = 0; wr_valid_in = 0; sv1 = 0;
      check_state();
   endtask

   task automatic load(input int slot, input int w[NW], input bit fs_on_commit);
      for (int i = 0; i < NW; i++) begin
         for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) step();
         for (int g = 0; g < 4 && !m_ready; g++) step();
         wr_valid_in = 1;
         wr_slot_in = (i == 0) ? 1'(slot) : 1'($urandom);
         wr_data_in = 8'(w[i]);
         step();
      end
      if (fs_on_commit) begin
         frame_start_in = 1;
         step();
      end else begin
         chk("commit_ready_low", 128'(wr_ready_out), 128'(0));
         step();
         chk("commit_ready_back", 128'(wr_ready_out), 128'(1));
      end
   endtask

   task automatic do_reset();
      rst_n_in = 0;
      m_reset();
      #1;
      check_state();
      @(negedge clk_in);
      rst_n_in = 1;
   endtask

   // scoreboard monitor: each applied frame_start must match the next queued kernel
   initial begin : mon
      exp_t e;
      forever begin
         @(posedge clk_in);
         if (frame_start_in && rst_n_in) begin
            #2;
            if (exp_q.size() == 0) chk("sb_underflow", 128'(1), 128'(0));
            else begin
               e = exp_q.pop_front();
               chk("sb_coeffs", 128'(coeffs_out), 128'(e.w[KK-1:0]));
               chk("sb_shift", 128'(shift_out), 128'(e.w[NW-2]));
               chk("sb_offset", 128'(offset_out), 128'(e.w[NW-1]));
               chk("sb_kid", 128'(kernel_id_out), 128'(e.kid));
            end
         end
      end
   end

   initial begin : stim
      int wa[NW], wb[NW], wc[NW], wd[NW];
      logic [KK*CW-1:0] v;
      #2;
      do_reset();
      step();
      // Gaussian select, applied only at frame_start
      sel_in = 3'd1; sel_valid_in = 1; step();
      chk("pend_before_fs", 128'(pending_out), 128'(1));
      chk("identity_before_fs", 128'(coeffs_out[4*CW +: CW]), 128'(1));
      frame_start_in = 1; step();
      chk("gauss_centre", 128'(coeffs_out[4*CW +: CW]), 128'(4));
      chk("gauss_corner", 128'(coeffs_out[0 +: CW]), 128'(1));
      chk("gauss_shift", 128'(shift_out), 128'(4));
      chk("gauss_kid", 128'(kernel_id_out), 128'(1));
      chk("gauss_pend", 128'(pending_out), 128'(0));
      // highest index is in range with two user slots
      sel_in = 3'd7; sel_valid_in = 1; step();
      chk("sel7_pending", 128'(pending_out), 128'(1));
      frame_start_in = 1; step();
      chk("sel7_kid", 128'(kernel_id_out), 128'(7));
      // single-slot instance: index 7 is out of range
      chk("dut1_idle", 128'({coeffs1, shift1, offset1, kid1, rdy1}),
          128'({72'h00_00_00_00_01_00_00_00_00, 8'h00, 8'h00, 3'd0, 1'b1}));
      sel1 = 3'd6; sv1 = 1; step();
      chk("dut1_sel6_pend", 128'(pend1), 128'(1));
      chk("dut1_sel6_noerr", 128'(err1), 128'(0));
      sel1 = 3'd7; sv1 = 1; step();
      chk("dut1_err_pulse", 128'(err1), 128'(1));
      chk("dut1_pend_kept", 128'(pend1), 128'(1));
      step();
      chk("dut1_err_clear", 128'(err1), 128'(0));
      // load slot 0 with a known kernel and activate it
      wa = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2, -3};
      load(0, wa, 0);
      sel_in = 3'd6; sel_valid_in = 1; step();
      frame_start_in = 1; step();
      for (int i = 0; i < KK; i++) v[i*CW +: CW] = CW'(i + 1);
      chk("slot0_coeffs", 128'(coeffs_out), 128'(v));
      chk("slot0_shift", 128'(shift_out), 128'(2));
      chk("slot0_offset", 128'(offset_out), 128'(8'hFD));
      // rewrite active slot mid-frame: held until next frame_start
      for (int i = 0; i < NW; i++) wb[i] = int'($urandom_range(0, 255));
      load(0, wb, 0);
      step();
      chk("rewrite_hold", 128'(coeffs_out), 128'(v));
      frame_start_in = 1; step();
      chk("rewrite_shift", 128'(shift_out), w8(wb[NW-2]));
      // commit coinciding with frame_start: old contents applied
      for (int i = 0; i < NW; i++) wc[i] = int'($urandom_range(0, 255));
      load(0, wc, 1);
      chk("commit_fs_old", 128'(offset_out), w8(wb[NW-1]));
      frame_start_in = 1; step();
      chk("commit_fs_new", 128'(offset_out), w8(wc[NW-1]));
      // reset in the middle of a load
      for (int i = 0; i < 5; i++) begin
         wr_valid_in = 1; wr_slot_in = 1'b1; wr_data_in = 8'($urandom); step();
      end
      #3;
      do_reset();
      chk("reset_identity", 128'(coeffs_out), 128'(72'h00_00_00_00_01_00_00_00_00));
      step();
      for (int i = 0; i < NW; i++) wd[i] = int'($urandom_range(0, 255));
      load(1, wd, 0);
      sel_in = 3'd7; sel_valid_in = 1; frame_start_in = 1; step();
      chk("fresh_load_shift", 128'(shift_out), w8(wd[NW-2]));
      sel_in = 3'd6; sel_valid_in = 1; step();
      frame_start_in = 1; step();
      chk("slot0_after_reset", 128'(coeffs_out[4*CW +: CW]), 128'(1));
      // select and frame_start in the same cycle
      sel_in = 3'd2; sel_valid_in = 1; frame_start_in = 1; step();
      chk("sharpen_centre", 128'(coeffs_out[4*CW +: CW]), 128'(5));
      chk("sharpen_offset", 128'(offset_out), 128'(16));
      chk("sharpen_pend", 128'(pending_out), 128'(0));
      // random traffic
      for (int n = 0; n < 400; n++) begin
         sel_valid_in = ($urandom_range(0, 3) == 0);
         sel_in = 3'($urandom_range(0, 7));
         frame_start_in = ($urandom_range(0, 9) == 0);
         wr_valid_in = ($urandom_range(0, 1) == 1);
         wr_slot_in = 1'($urandom);
         wr_data_in = 8'($urandom);
         step();
      end
      #20;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
